hilo_muldiv_ctrl: RTL and testbench
===================================

# hilo_muldiv_ctrl

Multi-cycle multiply/divide sequencer and HI/LO register owner for the EXE stage. It accepts MULT/MULTU/DIV/DIVU (plus optional MADD/MSUB family) and MTHI/MTLO from EXE, and runs an iterative radix-2 divider and a fixed-latency multiplier. While an operation is in flight it stalls the front of the pipeline, then commits the result to HI/LO. A MEM-stage flush aborts the operation without corrupting HI/LO.

## Interface
Parameters:
- MUL_LAT, 2: multiply compute cycles after the start cycle; legal range 1..8.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- EXE_Valid  in  1  EXE holds a live instruction.
- EXE_MDOp  in  4  op select. 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU, 9 MTHI, 10 MTLO. Values 11–15 mean none.
- EXE_BusA  in  32  rs operand, already forwarded.
- EXE_BusB  in  32  rt operand, already forwarded.
- MEM_Flush  in  1  exception flush; kills the EXE instruction.
- MD_Busy  out  1  stall request; holds PC/IF/ID/EXE.
- HI_Out  out  32  committed HI.
- LO_Out  out  32  committed LO.
- HILO_Wr  out  1  registered one-cycle pulse, high in the first cycle HI_Out/LO_Out show a new value.

## Operation
- **States:** IDLE, MUL, DIV, DONE.
- **start** = IDLE & EXE_Valid & !MEM_Flush & op in {1..8}.
- **IDLE:**
  - MTHI/MTLO with EXE_Valid & !MEM_Flush: write BusA to HI or LO at the clock edge. Busy stays 0.
  - start on a mul op: latch operands and op, go to MUL.
  - start on a div op: latch operands and op, go to DIV.
- **MUL:** counter runs 0..MUL_LAT-1.
  - Product width is 64 bits. Signed ops sign-extend the operands; unsigned ops zero-extend.
  - On the last count: {HI,LO} <= product (MULT/MULTU), {HI,LO} + product (MADD/MADDU), or {HI,LO} − product (MSUB/MSUBU). Arithmetic is modulo 2^64. Then go to DONE.
- **DIV:** restoring, one quotient bit per cycle, on magnitudes, 32 iterations.
  - Final cycle sign fix-up. Quotient is negated when the operand signs differ. Remainder takes the dividend's sign.
  - Writes LO = quotient and HI = remainder, then goes to DONE.
  - 0x80000000 / 0xFFFFFFFF (signed): LO = 0x80000000, HI = 0.
  - Divisor zero (detected at start): one DIV cycle, then LO = 0xFFFFFFFF and HI = BusA. No exception is raised.
- **DONE:** busy is 0 so the instruction leaves EXE. EXE_MDOp is ignored this cycle, so the same instruction is never restarted. Next state is IDLE.
- **MD_Busy** = start | (state==MUL) | (state==DIV).
- **MEM_Flush** in MUL or DIV: go to IDLE at the next edge with no HI/LO write. MD_Busy still follows the formula above during the flush cycle. In DONE or IDLE, flush only suppresses starts and MTHI/MTLO.
- Back-to-back ops: a new start is possible in the cycle after DONE.

## Timing
- Reset values: state IDLE, HI_Out = 0, LO_Out = 0, MD_Busy = 0, HILO_Wr = 0, counters 0.
- **Multiply started in cycle T:**
  - MD_Busy is high T..T+MUL_LAT.
  - HI/LO update at the end of T+MUL_LAT.
  - DONE and HILO_Wr are high in T+MUL_LAT+1.
  - EXE occupancy is MUL_LAT+2 cycles.
- **Divide started in cycle T:**
  - MD_Busy is high T..T+32; HI/LO update at the end of T+32.
  - DONE is T+33.
  - Divide by zero: MD_Busy high T..T+1, DONE at T+2.
- MTHI/MTLO in cycle T: new value visible, and HILO_Wr high, in T+1.
- HI_Out/LO_Out are register outputs with no bypass. A following MFHI in EXE reads them directly. The DONE cycle guarantees a one-cycle separation before any MFHI can use the result.
- Async reset mid-operation: immediately return to IDLE and zero HI/LO.

## Configuration
- **MADD_MSUB_EN defined:** ops 5–8 accumulate into {HI,LO} as described above.
- **MADD_MSUB_EN undefined:** ops 5–8 decode as none. There is no start, no busy and no write, and the accumulate adder/subtractor is not synthesized. The decoder is responsible for raising ReservedInstruction.

## Test plan
- Reset, then MULT with BusA = 0xFFFFFFFE (−2), BusB = 3, MUL_LAT = 2 → MD_Busy high 3 cycles; HI = 0xFFFFFFFF, LO = 0xFFFFFFFA; HILO_Wr pulses once.
- DIV with BusA = 0xFFFFFFF9 (−7), BusB = 2 → busy 33 cycles; LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 7/2 → LO = 3, HI = 1.
- DIVU with BusA = 0x1234, BusB = 0 → busy 2 cycles; LO = 0xFFFFFFFF, HI = 0x1234.
- DIV 100/3 started, MEM_Flush asserted in its 10th busy cycle → IDLE next cycle; HI/LO keep their prior values; no HILO_Wr.
- MTHI 0xA5A5A5A5 then MTLO 0x5A5A5A5A on consecutive cycles → no busy; each is visible the next cycle. With MADD_MSUB_EN: MADDU 0xFFFFFFFF × 2 → {HI,LO} = 0xA5A5A5A7_5A5A5A58.
- DIV immediately followed by MULT in EXE → MULT starts in the cycle after DONE and is not double-issued; final HI/LO equal the MULT result.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner and multi-cycle sequencer: fixed-latency multiply, radix-2 restoring divide.
// Define MADD_MSUB_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops (5..8).
module hilo_muldiv_ctrl #(
   parameter int unsigned MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        EXE_Valid,
   input  logic [3:0]  EXE_MDOp,
   input  logic [31:0] EXE_BusA,
   input  logic [31:0] EXE_BusB,
   input  logic        MEM_Flush,
   output logic        MD_Busy,
   output logic [31:0] HI_Out,
   output logic [31:0] LO_Out,
   output logic        HILO_Wr
);
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MADD  = 4'd5;
   localparam logic [3:0] OP_MADDU = 4'd6;
   localparam logic [3:0] OP_MSUB  = 4'd7;
   localparam logic [3:0] OP_MSUBU = 4'd8;
   localparam logic [3:0] OP_MTHI  = 4'd9;
   localparam logic [3:0] OP_MTLO  = 4'd10;

   state_t      state_q, state_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic [31:0] rem_q, rem_d, quo_q, quo_d;
   logic [3:0]  op_q, op_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        wr_q, wr_d, divz_q, divz_d, qneg_q, qneg_d, rneg_q, rneg_d;

   logic        is_mul, is_div, start, op_signed, new_signed;
   logic [63:0] a_ext, b_ext, product, mul_res;
   logic [32:0] rem_sh, diff;
   logic [31:0] rem_nx, quo_nx, a_mag, b_mag;

`ifdef MADD_MSUB_EN
   assign is_mul = (EXE_MDOp == OP_MULT) || (EXE_MDOp == OP_MULTU) ||
                   (EXE_MDOp >= OP_MADD && EXE_MDOp <= OP_MSUBU);
`else
   assign is_mul = (EXE_MDOp == OP_MULT) || (EXE_MDOp == OP_MULTU);
`endif
   assign is_div  = (EXE_MDOp == OP_DIV) || (EXE_MDOp == OP_DIVU);
   assign start   = (state_q == S_IDLE) && EXE_Valid && !MEM_Flush && (is_mul || is_div);
   assign MD_Busy = start || (state_q == S_MUL) || (state_q == S_DIV);

   // Multiply datapath works on the latched operands; signed ops sign-extend to 64 bits.
   assign op_signed = (op_q == OP_MULT) || (op_q == OP_DIV) || (op_q == OP_MADD) || (op_q == OP_MSUB);
   assign a_ext     = op_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
   assign b_ext     = op_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
   assign product   = a_ext * b_ext;

`ifdef MADD_MSUB_EN
   always_comb begin
      case (op_q)
         OP_MADD, OP_MADDU: mul_res = {hi_q, lo_q} + product;
         OP_MSUB, OP_MSUBU: mul_res = {hi_q, lo_q} - product;
         default:           mul_res = product;
      endcase
   end
`else
   assign mul_res = product;
`endif

   // One restoring step: quo_q shifts the dividend out MSB-first and the quotient in.
   assign rem_sh = {rem_q, quo_q[31]};
   assign diff   = rem_sh - {1'b0, b_q};
   assign rem_nx = diff[32] ? rem_sh[31:0] : diff[31:0];
   assign quo_nx = {quo_q[30:0], ~diff[32]};

   assign new_signed = (EXE_MDOp == OP_DIV);
   assign a_mag      = (new_signed && EXE_BusA[31]) ? -EXE_BusA : EXE_BusA;
   assign b_mag      = (new_signed && EXE_BusB[31]) ? -EXE_BusB : EXE_BusB;

   always_comb begin
      // NOTE: every _d starts as its _q so no path through the case leaves a latch.
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      a_d     = a_q;
      b_d     = b_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      divz_d  = divz_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      wr_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && is_mul) begin
               op_d    = EXE_MDOp;
               a_d     = EXE_BusA;
               b_d     = EXE_BusB;
               cnt_d   = 5'd0;
               state_d = S_MUL;
            end else if (start) begin
               op_d    = EXE_MDOp;
               a_d     = EXE_BusA;
               b_d     = b_mag;
               quo_d   = a_mag;
               rem_d   = 32'd0;
               cnt_d   = 5'd0;
               divz_d  = (EXE_BusB == 32'd0);
               qneg_d  = new_signed && (EXE_BusA[31] ^ EXE_BusB[31]);
               rneg_d  = new_signed && EXE_BusA[31];
               state_d = S_DIV;
            end else if (EXE_Valid && !MEM_Flush && EXE_MDOp == OP_MTHI) begin
               hi_d = EXE_BusA;
               wr_d = 1'b1;
            end else if (EXE_Valid && !MEM_Flush && EXE_MDOp == OP_MTLO) begin
               lo_d = EXE_BusA;
               wr_d = 1'b1;
            end
         end
         S_MUL: begin
            if (MEM_Flush) begin
               cnt_d   = 5'd0;
               state_d = S_IDLE;
            end else if (cnt_q == 5'(MUL_LAT - 1)) begin
               {hi_d, lo_d} = mul_res;
               wr_d    = 1'b1;
               cnt_d   = 5'd0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         S_DIV: begin
            if (MEM_Flush) begin
               cnt_d   = 5'd0;
               state_d = S_IDLE;
            end else if (divz_q) begin
               lo_d    = 32'hFFFF_FFFF;
               hi_d    = a_q;
               wr_d    = 1'b1;
               state_d = S_DONE;
            end else begin
               rem_d = rem_nx;
               quo_d = quo_nx;
               if (cnt_q == 5'd31) begin
                  lo_d    = qneg_q ? -quo_nx : quo_nx;
                  hi_d    = rneg_q ? -rem_nx : rem_nx;
                  wr_d    = 1'b1;
                  cnt_d   = 5'd0;
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: non-blocking updates only; async reset clears state, HI/LO and all datapath flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         op_q    <= '0;
         cnt_q   <= '0;
         divz_q  <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         divz_q  <= divz_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         wr_q    <= wr_d;
      end
   end

   assign HI_Out  = hi_q;
   assign LO_Out  = lo_q;
   assign HILO_Wr = wr_q;
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: a cycle model built from start time + latency and
// plain arithmetic is compared every cycle, plus literal results for each directed case.
module tb_hilo_muldiv_ctrl;
   localparam int unsigned MUL_LAT = 2;

   localparam logic [3:0] MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
   localparam logic [3:0] MADD = 4'd5, MADDU = 4'd6, MSUB = 4'd7, MSUBU = 4'd8;
   localparam logic [3:0] MTHI = 4'd9, MTLO = 4'd10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        EXE_Valid = 1'b0;
   logic [3:0]  EXE_MDOp = 4'd0;
   logic [31:0] EXE_BusA = 32'd0;
   logic [31:0] EXE_BusB = 32'd0;
   logic        MEM_Flush = 1'b0;
   logic        MD_Busy, HILO_Wr;
   logic [31:0] HI_Out, LO_Out;

   hilo_muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .rst(rst), .EXE_Valid(EXE_Valid), .EXE_MDOp(EXE_MDOp),
      .EXE_BusA(EXE_BusA), .EXE_BusB(EXE_BusB), .MEM_Flush(MEM_Flush),
      .MD_Busy(MD_Busy), .HI_Out(HI_Out), .LO_Out(LO_Out), .HILO_Wr(HILO_Wr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit is_start(input logic [3:0] op);
`ifdef MADD_MSUB_EN
      return op >= MULT && op <= MSUBU;
`else
      return op >= MULT && op <= DIVU;
`endif
   endfunction

   // Architectural result of an op, computed with native integer arithmetic.
   function automatic logic [63:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                                input logic [31:0] b, input logic [63:0] hilo);
      longint sa, sb;
      int     qa, qb;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (op == MULT || op == MADD || op == MSUB) p = 64'(sa * sb);
      else p = {32'd0, a} * {32'd0, b};
      case (op)
         MADD, MADDU: return hilo + p;
         MSUB, MSUBU: return hilo - p;
         DIV: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            qa = $signed(a);
            qb = $signed(b);
            return {32'(qa % qb), 32'(qa / qb)};
         end
         DIVU: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: return p;
      endcase
   endfunction

   // Model: an op started at cycle m_t finishes after m_l busy cycles, then one DONE cycle.
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_a = 32'd0, m_b = 32'd0;
   logic [3:0]  m_op = 4'd0;
   logic        m_wr = 1'b0, m_active = 1'b0, m_done = 1'b0;
   int          m_t = 0, m_l = 0, cyc = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_hi = 32'd0; m_lo = 32'd0; m_wr = 1'b0; m_active = 1'b0; m_done = 1'b0;
      end else begin
         m_wr = 1'b0;
         if (m_active) begin
            if (MEM_Flush) m_active = 1'b0;
            else if (cyc == m_t + m_l) begin
               {m_hi, m_lo} = model_result(m_op, m_a, m_b, {m_hi, m_lo});
               m_wr = 1'b1; m_active = 1'b0; m_done = 1'b1;
            end
         end else if (m_done) begin
            m_done = 1'b0;
         end else if (EXE_Valid && !MEM_Flush) begin
            if (is_start(EXE_MDOp)) begin
               m_active = 1'b1; m_t = cyc; m_op = EXE_MDOp; m_a = EXE_BusA; m_b = EXE_BusB;
               if (EXE_MDOp == DIV || EXE_MDOp == DIVU) m_l = (EXE_BusB == 32'd0) ? 1 : 32;
               else m_l = int'(MUL_LAT);
            end else if (EXE_MDOp == MTHI) begin
               m_hi = EXE_BusA; m_wr = 1'b1;
            end else if (EXE_MDOp == MTLO) begin
               m_lo = EXE_BusA; m_wr = 1'b1;
            end
         end
         cyc++;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("md_busy", 64'(MD_Busy),
               64'(m_active || (!m_done && EXE_Valid && !MEM_Flush && is_start(EXE_MDOp))));
         check("hilo_wr", 64'(HILO_Wr), 64'(m_wr));
         check("hi_out", 64'(HI_Out), 64'(m_hi));
         check("lo_out", 64'(LO_Out), 64'(m_lo));
         if (HILO_Wr) wr_cnt++;
      end
   end

   // Presents one instruction in EXE and holds it while MD_Busy, like the stalled pipeline.
   // Called at posedge+2; returns at posedge+2 of the cycle after the instruction leaves.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, output int busy_cycles);
      bit b_s, left;
      left = 1'b0;
      busy_cycles = 0;
      EXE_Valid = 1'b1; EXE_MDOp = op; EXE_BusA = a; EXE_BusB = b; MEM_Flush = 1'b0;
      for (int i = 0; i < 100 && !left; i++) begin
         if (i == flush_at) MEM_Flush = 1'b1;
         @(negedge clk);
         b_s = MD_Busy;
         if (b_s) busy_cycles++;
         @(posedge clk);
         #2;
         if (MEM_Flush || !b_s) left = 1'b1;
      end
      if (!left) check("issue_timeout", 64'd1, 64'd0);
      EXE_Valid = 1'b0; EXE_MDOp = 4'd0; MEM_Flush = 1'b0;
   endtask

   task automatic settle();
      @(negedge clk);
      @(posedge clk);
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int bc, bc2, w0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("reset_hi", 64'(HI_Out), 64'd0);
      check("reset_lo", 64'(LO_Out), 64'd0);
      check("reset_busy", 64'(MD_Busy), 64'd0);
      check("reset_wr", 64'(HILO_Wr), 64'd0);
      @(posedge clk); #2;

      w0 = wr_cnt;
      issue(MULT, 32'hFFFF_FFFE, 32'd3, -1, bc); settle();
      check("mult_busy", 64'(bc), 64'd3);
      check("mult_res", {HI_Out, LO_Out}, 64'hFFFF_FFFF_FFFF_FFFA);
      check("mult_wr", 64'(wr_cnt - w0), 64'd1);

      issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, bc); settle();
      check("multu_res", {HI_Out, LO_Out}, 64'hFFFF_FFFE_0000_0001);

      issue(DIV, 32'hFFFF_FFF9, 32'd2, -1, bc); settle();
      check("div_busy", 64'(bc), 64'd33);
      check("div_res", {HI_Out, LO_Out}, 64'hFFFF_FFFF_FFFF_FFFD);

      issue(DIVU, 32'd7, 32'd2, -1, bc); settle();
      check("divu_res", {HI_Out, LO_Out}, 64'h0000_0001_0000_0003);

      issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, bc); settle();
      check("div_ovf_res", {HI_Out, LO_Out}, 64'h0000_0000_8000_0000);

      issue(DIVU, 32'h1234, 32'd0, -1, bc); settle();
      check("divz_busy", 64'(bc), 64'd2);
      check("divz_res", {HI_Out, LO_Out}, 64'h0000_1234_FFFF_FFFF);

      w0 = wr_cnt;
      issue(DIV, 32'd100, 32'd3, 9, bc); settle();
      check("flush_busy", 64'(bc), 64'd10);
      check("flush_res", {HI_Out, LO_Out}, 64'h0000_1234_FFFF_FFFF);
      check("flush_wr", 64'(wr_cnt - w0), 64'd0);

      issue(4'd12, 32'd5, 32'd6, -1, bc); settle();
      check("none_busy", 64'(bc), 64'd0);

      issue(MTHI, 32'hA5A5_A5A5, 32'd0, -1, bc);
      check("mthi_hi", 64'(HI_Out), 64'hA5A5_A5A5);
      issue(MTLO, 32'h5A5A_5A5A, 32'd0, -1, bc2);
      check("mtlo_lo", 64'(LO_Out), 64'h5A5A_5A5A);
      check("mt_busy", 64'(bc + bc2), 64'd0);
      settle();

      w0 = wr_cnt;
      issue(MADDU, 32'hFFFF_FFFF, 32'd2, -1, bc); settle();
`ifdef MADD_MSUB_EN
      check("maddu_busy", 64'(bc), 64'd3);
      check("maddu_res", {HI_Out, LO_Out}, 64'hA5A5_A5A7_5A5A_5A58);
      check("maddu_wr", 64'(wr_cnt - w0), 64'd1);
`else
      check("maddu_busy", 64'(bc), 64'd0);
      check("maddu_res", {HI_Out, LO_Out}, 64'hA5A5_A5A5_5A5A_5A5A);
      check("maddu_wr", 64'(wr_cnt - w0), 64'd0);
`endif

      w0 = wr_cnt;
      issue(DIV, 32'd100, 32'd3, -1, bc);
      issue(MULT, 32'd7, 32'hFFFF_FFFB, -1, bc2); settle();
      check("b2b_div_busy", 64'(bc), 64'd33);
      check("b2b_mult_busy", 64'(bc2), 64'd3);
      check("b2b_wr", 64'(wr_cnt - w0), 64'd2);
      check("b2b_res", {HI_Out, LO_Out}, 64'hFFFF_FFFF_FFFF_FFDD);

      EXE_Valid = 1'b1; EXE_MDOp = DIV; EXE_BusA = 32'd1000; EXE_BusB = 32'd7;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1; EXE_Valid = 1'b0; EXE_MDOp = 4'd0;
      #1;
      check("areset_hi", 64'(HI_Out), 64'd0);
      check("areset_lo", 64'(LO_Out), 64'd0);
      check("areset_busy", 64'(MD_Busy), 64'd0);
      check("areset_wr", 64'(HILO_Wr), 64'd0);
      @(posedge clk); #2 rst = 1'b0;
      settle();

      issue(DIVU, 32'd1000, 32'd7, -1, bc); settle();
      check("post_reset_divu", {HI_Out, LO_Out}, 64'h0000_0006_0000_008E);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
